// File: rtl/axis_trigger_scope.sv
// Multi-channel capture controller: pass-through stream, circular write address, pre-trigger window, level/edge trigger; TRG_TIMESTAMP_EN adds ts_data.
// Zero-latency combinational pass-through; s_axis_tready is tied high, so no backpressure is ever applied upstream.
module axis_trigger_scope #(
  parameter int CHANNELS   = 2,
  parameter int CH_WIDTH   = 16,
  parameter int CNTR_WIDTH = 12,
  parameter int TS_WIDTH   = 32,
  localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         run_flag,
  input  logic                         trg_flag,
  input  logic [1:0]                   trg_mode,
  input  logic [SEL_W-1:0]             trg_chan,
  input  logic signed [CH_WIDTH-1:0]   trg_level,
  input  logic [CNTR_WIDTH-1:0]        pre_data,
  input  logic [CNTR_WIDTH-1:0]        tot_data,
  output logic [CNTR_WIDTH+1:0]        sts_data,
  output logic                         s_axis_tready,
  input  logic [CHANNELS*CH_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic [CHANNELS*CH_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic [CNTR_WIDTH-1:0]        m_axis_tuser
`ifdef TRG_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]          ts_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ARMED, S_POST} state_t;

  state_t                     state, state_nxt;
  logic [CNTR_WIDTH-1:0]      addr, trg_addr, pre_cnt, post_cnt, post_len;
  logic [CNTR_WIDTH-1:0]      pre_cnt_inc, post_cnt_inc;
  logic                       done, prev_valid;
  logic signed [CH_WIDTH-1:0] prev, cur;
  logic                       active, accepted, hit_rise, hit_fall, hit;
  logic                       start, trg_take, post_end;

  if (TS_WIDTH < 1) begin : g_ts_width_check
    $error("TS_WIDTH must be at least 1");
  end

  assign active        = (state != S_IDLE);
  assign accepted      = active && s_axis_tvalid;
  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = accepted;
  assign m_axis_tuser  = addr;
  assign sts_data      = {trg_addr, done, active};
  assign pre_cnt_inc   = pre_cnt + 1'b1;
  assign post_cnt_inc  = post_cnt + 1'b1;
  assign post_len      = (tot_data > pre_data) ? (tot_data - pre_data) : CNTR_WIDTH'(1);

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    cur = s_axis_tdata[CH_WIDTH-1:0];
    for (int k = 1; k < CHANNELS; k++) begin
      if (trg_chan == SEL_W'(k)) cur = s_axis_tdata[k*CH_WIDTH +: CH_WIDTH];
    end
  end

  assign hit_rise = prev_valid && (prev < trg_level) && (cur >= trg_level);
  assign hit_fall = prev_valid && (prev >= trg_level) && (cur < trg_level);

  always_comb begin
    hit = 1'b0;
    case (trg_mode)
      2'b00:   hit = trg_flag;
      2'b01:   hit = hit_rise;
      2'b10:   hit = hit_fall;
      default: hit = hit_rise || hit_fall;
    endcase
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    trg_take  = 1'b0;
    post_end  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_flag) begin
          state_nxt = S_PRE;
          start     = 1'b1;
        end
      end
      S_PRE: begin
        if ((pre_data == '0) || (accepted && (pre_cnt_inc == pre_data))) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (accepted && hit) begin
          trg_take = 1'b1;
          // A one-sample post window completes on the trigger sample itself.
          if (post_len == CNTR_WIDTH'(1)) begin
            state_nxt = S_IDLE;
            post_end  = 1'b1;
          end else begin
            state_nxt = S_POST;
          end
        end
      end
      default: begin
        if (accepted && (post_cnt_inc == post_len)) begin
          state_nxt = S_IDLE;
          post_end  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_IDLE;
      addr       <= '0;
      trg_addr   <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      done       <= 1'b0;
      prev_valid <= 1'b0;
      prev       <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr       <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        done       <= 1'b0;
        prev_valid <= 1'b0;
      end else begin
        if (accepted) begin
          addr       <= addr + 1'b1;
          prev       <= cur;
          prev_valid <= 1'b1;
        end
        if ((state == S_PRE) && accepted) pre_cnt <= pre_cnt_inc;
        if (trg_take) begin
          trg_addr <= addr;
          post_cnt <= CNTR_WIDTH'(1);
        end else if ((state == S_POST) && accepted) begin
          post_cnt <= post_cnt_inc;
        end
        if (post_end) done <= 1'b1;
      end
    end
  end

`ifdef TRG_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      ts_cnt  <= '0;
      ts_data <= '0;
    end else if (start) begin
      ts_cnt <= '0;
    end else begin
      if (accepted && (ts_cnt != '1)) ts_cnt <= ts_cnt + 1'b1;
      if (trg_take) ts_data <= ts_cnt;
    end
  end
`endif

endmodule
